// File: rtl/vend_fsm_param.sv
// Coin-accumulating vending controller with a configurable price. Change is paid
// out as one 10c/5c ejector pulse per cycle, largest coin first.
module vend_fsm_param #(
    parameter int PRICE_U = 4,
    parameter int CW      = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    coin,
    input  logic          cancel,
    output logic          dispense,
    output logic          chg_10,
    output logic          chg_5,
    output logic          coin_reject,
    output logic          busy,
    output logic [CW-1:0] credit
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2
    } state_t;

    localparam logic [CW-1:0] PRICE = CW'(PRICE_U);

    state_t        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [CW-1:0] chg_q, chg_d;
    logic [CW-1:0] v, sum;
    logic          reject_d;
    logic          dispense_q, chg_10_q, chg_5_q, coin_reject_q, busy_q;

    always_comb begin
        case (coin)
            2'b01:   v = CW'(1);
            2'b10:   v = CW'(2);
            2'b11:   v = CW'(5);
            default: v = '0;
        endcase
        sum      = credit_q + v;
        state_d  = state_q;
        credit_d = credit_q;
        chg_d    = chg_q;
        reject_d = (state_q != COLLECT) && (coin != 2'b00);

        case (state_q)
            COLLECT: begin
                // Cancel wins over vending; a coin arriving with it is refunded too.
                if (cancel) begin
                    if (sum != '0) begin
                        chg_d    = sum;
                        credit_d = '0;
                        state_d  = CHANGE;
                    end
                end else if (sum >= PRICE) begin
                    chg_d    = sum - PRICE;
                    credit_d = '0;
                    state_d  = VEND;
                end else begin
                    credit_d = sum;
                end
            end
            VEND: begin
                state_d = (chg_q != '0) ? CHANGE : COLLECT;
            end
            CHANGE: begin
                if (chg_q >= CW'(2)) begin
                    chg_d = chg_q - CW'(2);
                end else if (chg_q != '0) begin
                    chg_d = chg_q - CW'(1);
                end
                state_d = (chg_d == '0) ? COLLECT : CHANGE;
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // Outputs are registered from the next state, so each CHANGE cycle shows the
    // pulse for the amount still pending in chg_q during that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= COLLECT;
            credit_q      <= '0;
            chg_q         <= '0;
            dispense_q    <= 1'b0;
            chg_10_q      <= 1'b0;
            chg_5_q       <= 1'b0;
            coin_reject_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            chg_q         <= chg_d;
            dispense_q    <= (state_d == VEND);
            chg_10_q      <= (state_d == CHANGE) && (chg_d >= CW'(2));
            chg_5_q       <= (state_d == CHANGE) && (chg_d == CW'(1));
            coin_reject_q <= reject_d;
            busy_q        <= (state_d != COLLECT);
        end
    end

    assign dispense    = dispense_q;
    assign chg_10      = chg_10_q;
    assign chg_5       = chg_5_q;
    assign coin_reject = coin_reject_q;
    assign busy        = busy_q;
    assign credit      = credit_q;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Directed bench for vend_fsm_param: one instance at 20c and one at 35c, every
// output vector checked one time unit after each rising edge.
module tb_vend_fsm_param;

    logic       clk;
    logic       rst;
    logic [1:0] coin4, coin7;
    logic       cancel4, cancel7;
    logic       disp4, c10_4, c5_4, rej4, busy4;
    logic       disp7, c10_7, c5_7, rej7, busy7;
    logic [6:0] cr4, cr7;
    logic [11:0] obs4, obs7;

    int n_vec = 0;
    int n_err = 0;

    vend_fsm_param #(.PRICE_U(4), .CW(7)) u4 (
        .clk(clk), .rst(rst), .coin(coin4), .cancel(cancel4),
        .dispense(disp4), .chg_10(c10_4), .chg_5(c5_4),
        .coin_reject(rej4), .busy(busy4), .credit(cr4)
    );

    vend_fsm_param #(.PRICE_U(7), .CW(7)) u7 (
        .clk(clk), .rst(rst), .coin(coin7), .cancel(cancel7),
        .dispense(disp7), .chg_10(c10_7), .chg_5(c5_7),
        .coin_reject(rej7), .busy(busy7), .credit(cr7)
    );

    assign obs4 = {disp4, c10_4, c5_4, rej4, busy4, cr4};
    assign obs7 = {disp7, c10_7, c5_7, rej7, busy7, cr7};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector: {dispense, chg_10, chg_5, coin_reject, busy, credit}
    function automatic logic [11:0] e(input logic d, input logic c10, input logic c5,
                                      input logic rj, input logic bz, input int cr);
        return {d, c10, c5, rj, bz, 7'(cr)};
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc4(input logic [1:0] c, input logic cn);
        coin4 = c;
        cancel4 = cn;
        @(posedge clk);
        #1;
        coin4 = 2'b00;
        cancel4 = 1'b0;
    endtask

    task automatic cyc7(input logic [1:0] c, input logic cn);
        coin7 = c;
        cancel7 = cn;
        @(posedge clk);
        #1;
        coin7 = 2'b00;
        cancel7 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        coin4 = 2'b00; cancel4 = 1'b0;
        coin7 = 2'b00; cancel7 = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_u4", obs4, e(0,0,0,0,0,0));
        chk("rst_u7", obs7, e(0,0,0,0,0,0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_u4", obs4, e(0,0,0,0,0,0));

        // 10 + 10 -> exact price, no change
        cyc4(2'b10, 1'b0); chk("t1_credit2",  obs4, e(0,0,0,0,0,2));
        cyc4(2'b10, 1'b0); chk("t1_dispense", obs4, e(1,0,0,0,1,0));
        cyc4(2'b00, 1'b0); chk("t1_idle",     obs4, e(0,0,0,0,0,0));

        // 5 + 10 + 25 -> 40c, change 20c as two dimes
        cyc4(2'b01, 1'b0); chk("t2_credit1",  obs4, e(0,0,0,0,0,1));
        cyc4(2'b10, 1'b0); chk("t2_credit3",  obs4, e(0,0,0,0,0,3));
        cyc4(2'b11, 1'b0); chk("t2_dispense", obs4, e(1,0,0,0,1,0));
        cyc4(2'b00, 1'b0); chk("t2_chg10_a",  obs4, e(0,1,0,0,1,0));
        cyc4(2'b00, 1'b0); chk("t2_chg10_b",  obs4, e(0,1,0,0,1,0));
        cyc4(2'b00, 1'b0); chk("t2_idle",     obs4, e(0,0,0,0,0,0));

        // 5 + 10 then cancel -> refund 15c as dime then nickel
        cyc4(2'b01, 1'b0); chk("t3_credit1",  obs4, e(0,0,0,0,0,1));
        cyc4(2'b10, 1'b0); chk("t3_credit3",  obs4, e(0,0,0,0,0,3));
        cyc4(2'b00, 1'b1); chk("t3_ref10",    obs4, e(0,1,0,0,1,0));
        cyc4(2'b00, 1'b0); chk("t3_ref5",     obs4, e(0,0,1,0,1,0));
        cyc4(2'b00, 1'b0); chk("t3_idle",     obs4, e(0,0,0,0,0,0));
        cyc4(2'b00, 1'b1); chk("t3_cancel0",  obs4, e(0,0,0,0,0,0));

        // 25 -> vend, change 5c; a dime during the chg_5 cycle is rejected
        cyc4(2'b11, 1'b0); chk("t4_dispense", obs4, e(1,0,0,0,1,0));
        cyc4(2'b00, 1'b0); chk("t4_chg5",     obs4, e(0,0,1,0,1,0));
        cyc4(2'b10, 1'b0); chk("t4_reject",   obs4, e(0,0,0,1,0,0));
        cyc4(2'b00, 1'b0); chk("t4_idle",     obs4, e(0,0,0,0,0,0));

        // Coin during VEND is rejected and not credited
        cyc4(2'b10, 1'b0); chk("t4b_credit2", obs4, e(0,0,0,0,0,2));
        cyc4(2'b10, 1'b0); chk("t4b_disp",    obs4, e(1,0,0,0,1,0));
        cyc4(2'b01, 1'b0); chk("t4b_reject",  obs4, e(0,0,0,1,0,0));
        cyc4(2'b00, 1'b0); chk("t4b_idle",    obs4, e(0,0,0,0,0,0));

        // Reset in the middle of paying change
        cyc4(2'b01, 1'b0); chk("t5_credit1",  obs4, e(0,0,0,0,0,1));
        cyc4(2'b10, 1'b0); chk("t5_credit3",  obs4, e(0,0,0,0,0,3));
        cyc4(2'b11, 1'b0); chk("t5_dispense", obs4, e(1,0,0,0,1,0));
        cyc4(2'b00, 1'b0); chk("t5_chg10",    obs4, e(0,1,0,0,1,0));
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_rst", obs4, e(0,0,0,0,0,0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_no_more_chg", obs4, e(0,0,0,0,0,0));
        cyc4(2'b10, 1'b0); chk("t5_credit2",  obs4, e(0,0,0,0,0,2));

        // 35c instance: 25 + 25 -> change 15c
        cyc7(2'b11, 1'b0); chk("t6_credit5",  obs7, e(0,0,0,0,0,5));
        cyc7(2'b11, 1'b0); chk("t6_dispense", obs7, e(1,0,0,0,1,0));
        cyc7(2'b00, 1'b0); chk("t6_chg10",    obs7, e(0,1,0,0,1,0));
        cyc7(2'b00, 1'b0); chk("t6_chg5",     obs7, e(0,0,1,0,1,0));
        cyc7(2'b00, 1'b0); chk("t6_idle",     obs7, e(0,0,0,0,0,0));

        // Cancel together with a quarter from zero credit refunds the quarter
        cyc7(2'b11, 1'b1); chk("t6_ref10_a",  obs7, e(0,1,0,0,1,0));
        cyc7(2'b00, 1'b0); chk("t6_ref10_b",  obs7, e(0,1,0,0,1,0));
        cyc7(2'b00, 1'b0); chk("t6_ref5",     obs7, e(0,0,1,0,1,0));
        cyc7(2'b00, 1'b0); chk("t6_idle2",    obs7, e(0,0,0,0,0,0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vend_fsm_param.md
Name: vend_fsm_param

Overview:
- Parametrised successor of the team's fixed-price soda vending controller.
- Accumulates coins of 5¢, 10¢ and 25¢ against a configurable price and vends.
- Returns change as a sequence of one-cycle 10¢/5¢ coin-ejector pulses, largest first.
- Supports a cancel/refund request and rejects coins while busy. Sits between the coin-acceptor decoder and the product/change ejector drivers.

Parameters:
- PRICE_U, 4, product price in 5¢ units (4 = 20¢); legal range 1..60.
- CW, 7, width of the credit and change registers; must satisfy 2^CW > PRICE_U+4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- coin  in  2  coin code: 00 none, 01 5¢, 10 10¢, 11 25¢. Each cycle with a non-zero code is one coin; the upstream block pulses one cycle per coin.
- cancel  in  1  refund request, sampled each cycle.
- dispense  out  1  one-cycle product release pulse.
- chg_10  out  1  one-cycle pulse: eject one 10¢ coin.
- chg_5  out  1  one-cycle pulse: eject one 5¢ coin.
- coin_reject  out  1  one-cycle pulse: the coin was not credited and is routed to return.
- busy  out  1  high when the state is not COLLECT.
- credit  out  CW  current credit in 5¢ units.

Behaviour:
- Coin value v in units: 01→1, 10→2, 11→5, 00→0.
- All outputs are registered (Moore). Reset and reset mid-operation force:
  - state COLLECT, credit=0, change register chg=0;
  - every output 0;
  - any pending change is discarded.
- The state register is 2 bits: COLLECT, VEND, CHANGE.
- COLLECT, evaluated at each rising edge. Let sum = credit+v:
  - cancel=1 and sum>0 → chg=sum, credit=0, next CHANGE. No dispense. Cancel has priority over vending, and a simultaneous coin is refunded.
  - cancel=1 and sum=0 → ignored, stay in COLLECT.
  - cancel=0 and sum>=PRICE_U → chg=sum-PRICE_U, credit=0, next VEND.
  - otherwise → credit=sum, stay in COLLECT.
- Credit never exceeds PRICE_U-1 in COLLECT. chg never exceeds 4 for a vend, or PRICE_U+4 for a refund.
- VEND: dispense=1 for exactly this one cycle. Next state is CHANGE if chg>0, else COLLECT.
- CHANGE, one ejector pulse per cycle:
  - if chg>=2 → chg_10=1, chg-=2;
  - else → chg_5=1, chg-=1.
  - When chg reaches 0 after the pulse → next COLLECT.
  - chg_10 and chg_5 are never high together. Neither is high in the same cycle as dispense.
- Latency:
  - dispense is high in the cycle after the edge that sampled the completing coin.
  - The first change pulse follows dispense in the next cycle.
- Any non-zero coin sampled while in VEND or CHANGE:
  - is not credited;
  - coin_reject=1 in the following cycle.
- cancel in VEND or CHANGE is ignored.
- credit holds its value in VEND/CHANGE, where it is 0.

Test Plan:
- PRICE_U=4: rst; coin 10,10 on consecutive cycles → credit 0→2→0, dispense pulse one cycle after the second coin, no chg pulses, busy high 1 cycle.
- PRICE_U=4: coin 5, 10, 25 → credit 1,3, then dispense, then chg_10, chg_10 (change 20¢), busy low afterwards, credit 0.
- PRICE_U=4: coin 5, 10, then cancel → no dispense; chg_10 then chg_5; credit returns to 0.
- PRICE_U=4: coin 25 (vend, change 1), then coin 10 during the chg_5 cycle → coin_reject pulse next cycle, credit stays 0.
- PRICE_U=4: coin 5, 10, 25, assert rst during the first chg_10 → all outputs 0 immediately, no further chg pulses; next coin 10 gives credit 2.
- PRICE_U=7 (35¢), CW=7: coin 25, 25 → dispense, then chg_10, chg_5 (change 3 units); simultaneous cancel+coin 25 from credit 0 → chg_10, chg_10, chg_5, no dispense.
